// File: rtl/data_memory_ws.sv
// data_memory_ws: word-addressed data memory for the MEM stage with a
// programmable number of wait states and a ready handshake.
// Optional feature: define DATA_MEMORY_WS_BOUNDS_CHECK_EN to flag
// out-of-range or misaligned accesses. A flagged access suppresses its write,
// reads back 0 and pulses err_out in DONE. Without the macro, err_out is 0,
// the low address bits are ignored and the index wraps modulo WORD_COUNT.
module data_memory_ws #(
    parameter int          WORD_COUNT  = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic        mem_read_enable_in,
    input  logic        mem_write_enable_in,
    output logic [31:0] result_out,
    output logic        ready_out,
    output logic        err_out
);

    localparam int IDX_W = $clog2(WORD_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cnt;
    logic [7:0]         cnt_nxt;
    logic               request;
    logic               latch_en;
    logic               access_en;

    logic [31:0]        lat_addr;
    logic [31:0]        lat_data;
    logic               lat_wr;

    logic [31:0]        off;
    logic [31:0]        off_words;
    logic [IDX_W-1:0]   idx;
    logic               oor;

    logic [31:0]        mem [WORD_COUNT];

    assign request = mem_read_enable_in | mem_write_enable_in;

    // Next-state, wait counter and handshake decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        access_en = 1'b0;
        ready_out = 1'b0;
        case (state)
            S_IDLE: begin
                ready_out = ~request;
                if (request) begin
                    latch_en  = 1'b1;
                    cnt_nxt   = 8'(WAIT_STATES);
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 8'd0) begin
                    access_en = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DONE: begin
                ready_out = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request in IDLE; later input changes are ignored
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_addr <= alu_res_in;
            lat_data <= val_rm_in;
            lat_wr   <= mem_write_enable_in;
        end
    end

    // Word index relative to the base address (wraps modulo 2^32 below base)
    assign off       = lat_addr - BASE_ADDR;
    assign off_words = {2'b00, off[31:2]};
    assign idx       = off_words[IDX_W-1:0];

`ifdef DATA_MEMORY_WS_BOUNDS_CHECK_EN
    assign oor = (lat_addr < BASE_ADDR) || (lat_addr[1:0] != 2'b00) ||
                 (off_words >= 32'(WORD_COUNT));

    logic unused_bits;
    assign unused_bits = ^off[1:0];

    // Error flag is a one-cycle pulse that lines up with DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            err_out <= 1'b0;
        end else begin
            err_out <= access_en & oor;
        end
    end
`else
    assign oor     = 1'b0;
    assign err_out = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{off[1:0], off_words[31:IDX_W]};
`endif

    // Array write; reset on the access edge aborts the commit
    always_ff @(posedge clk) begin
        if (access_en && lat_wr && !oor && !rst) begin
            mem[idx] <= lat_data;
        end
    end

    // Load result register, held until the next read access
    always_ff @(posedge clk) begin
        if (rst) begin
            result_out <= 32'd0;
        end else if (access_en && !lat_wr) begin
            result_out <= oor ? 32'd0 : mem[idx];
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: directed handshake/boundary steps
// followed by randomized accesses checked against a behavioural model.
module tb_data_memory_ws;

    localparam int          WS   = 2;
    localparam int          WC   = 64;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, res;
    logic        rd, wr, rdy, err;
    logic [31:0] addr0, wdata0, res0;
    logic        rd0, wr0, rdy0, err0;

    int          n_chk  = 0;
    int          n_fail = 0;

    logic [31:0] mdl  [WC];
    logic [31:0] mdl0 [WC];
    logic [31:0] exp_res;
    logic [31:0] exp_res0;

    always #5 clk = ~clk;

    data_memory_ws #(.WORD_COUNT(WC), .BASE_ADDR(BASE), .WAIT_STATES(WS)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .alu_res_in          (addr),
        .val_rm_in           (wdata),
        .mem_read_enable_in  (rd),
        .mem_write_enable_in (wr),
        .result_out          (res),
        .ready_out           (rdy),
        .err_out             (err)
    );

    data_memory_ws #(.WORD_COUNT(WC), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut_ws0 (
        .clk                 (clk),
        .rst                 (rst),
        .alu_res_in          (addr0),
        .val_rm_in           (wdata0),
        .mem_read_enable_in  (rd0),
        .mem_write_enable_in (wr0),
        .result_out          (res0),
        .ready_out           (rdy0),
        .err_out             (err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Spec-level address rules
    function automatic bit out_of_range(input logic [31:0] a);
        logic [31:0] lo;
        lo = a;
`ifdef DATA_MEMORY_WS_BOUNDS_CHECK_EN
        if (a < BASE) return 1'b1;
        if (lo[1:0] != 2'b00) return 1'b1;
        if (((a - BASE) / 32'd4) >= 32'(WC)) return 1'b1;
        return 1'b0;
`else
        return (lo == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - BASE) / 32'd4) % 32'(WC));
    endfunction

    // One access on the WAIT_STATES=2 instance, starting in an IDLE cycle.
    // drop: deassert the request after cycle 0. hold: keep it through DONE.
    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w, input bit drop, input bit hold);
        logic [31:0] prev;
        bit          bad;
        int          wi;
        bad  = out_of_range(a);
        wi   = word_of(a);
        prev = exp_res;
        addr = a; wdata = d; rd = r; wr = w;
        #1;
        chk("ready_cycle0", 32'(rdy), 32'd0);
        for (int k = 1; k <= WS + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1 && drop) begin
                rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
            end
            chk("ready_busy", 32'(rdy), 32'd0);
            chk("result_busy", res, prev);
            chk("err_busy", 32'(err), 32'd0);
        end
        if (w) begin
            if (!bad) mdl[wi] = d;
        end else begin
            exp_res = bad ? 32'd0 : mdl[wi];
        end
        @(posedge clk); #1;
        chk("ready_done", 32'(rdy), 32'd1);
        chk("result_done", res, exp_res);
        chk("err_done", 32'(err), 32'(bad));
        if (!hold) begin
            rd = 1'b0; wr = 1'b0;
        end
        @(posedge clk); #1;
        if (!hold) chk("ready_idle", 32'(rdy), 32'd1);
    endtask

    // One access on the zero-wait-state instance; request dropped after cycle 0
    task automatic access_ws0(input logic [31:0] a, input logic [31:0] d,
                              input logic r, input logic w);
        logic [31:0] prev;
        prev  = exp_res0;
        addr0 = a; wdata0 = d; rd0 = r; wr0 = w;
        #1;
        chk("ws0_ready_cycle0", 32'(rdy0), 32'd0);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
        chk("ws0_ready_cycle1", 32'(rdy0), 32'd0);
        chk("ws0_result_busy", res0, prev);
        if (w) mdl0[word_of(a)] = d;
        else   exp_res0 = mdl0[word_of(a)];
        @(posedge clk); #1;
        chk("ws0_ready_done", 32'(rdy0), 32'd1);
        chk("ws0_result_done", res0, exp_res0);
        @(posedge clk); #1;
        chk("ws0_ready_idle", 32'(rdy0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        int          sel, op;
        rst = 1'b1;
        addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0;
        addr0 = '0; wdata0 = '0; rd0 = 1'b0; wr0 = 1'b0;
        exp_res = '0; exp_res0 = '0;

        // Reset values
        @(posedge clk); #1;
        chk("rst_result", res, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready_noreq", 32'(rdy), 32'd1);
        chk("rst_ws0_ready", 32'(rdy0), 32'd1);
        rd = 1'b1; addr = BASE;
        #1;
        chk("rst_ready_req", 32'(rdy), 32'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Give every word a defined value
        for (int i = 0; i < WC; i++) access(BASE + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);

        // Write then read back
        access(BASE, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        access(BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("deadbeef", res, 32'hDEAD_BEEF);

        // Read and write together behave as a write
        access(32'd1028, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rw_result_kept", res, 32'hDEAD_BEEF);
        access(32'd1028, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rw_word1", res, 32'd5);

        // Index 64: wraps onto word 0, or is rejected with the checker
        access(32'd1024, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        access(32'd1280, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        access(32'd1024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DATA_MEMORY_WS_BOUNDS_CHECK_EN
        chk("idx64", res, 32'h11);
`else
        chk("idx64", res, 32'h22);
`endif

        // Reset on the edge where a write is due: write must not land
        access(32'd1032, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        addr = 32'd1032; wdata = 32'hA5; wr = 1'b1;
        for (int k = 1; k <= WS + 1; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; wr = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy_ready", 32'(rdy), 32'd1);
        chk("rstbusy_result", res, 32'd0);
        chk("rstbusy_err", 32'(err), 32'd0);
        exp_res = 32'd0; exp_res0 = 32'd0;
        rst = 1'b0;
        access(32'd1032, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstbusy_abort", res, 32'h77);

        // Zero wait states, request dropped after acceptance
        access_ws0(32'd1040, 32'h1234, 1'b0, 1'b1);
        access_ws0(32'd1040, 32'h0, 1'b1, 1'b0);
        chk("ws0_readback", res0, 32'h1234);

        // Request held across DONE: next access starts in the following IDLE
        access(BASE + 32'd8, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        access(BASE + 32'd8, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        access(BASE + 32'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        access(BASE + 32'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_read", res, 32'h55);

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = BASE + 32'(4 * $urandom_range(0, WC - 1)) + 32'($urandom_range(1, 3));
                1:       a = BASE - 32'(4 * $urandom_range(1, 8));
                2:       a = BASE + 32'(4 * WC) + 32'(4 * $urandom_range(0, 15));
                default: a = BASE + 32'(4 * $urandom_range(0, WC - 1));
            endcase
            d  = $urandom;
            op = int'($urandom_range(0, 2));
            access(a, d, op != 1, op != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ws.md
# data_memory_ws

Parametrised, wait-state data memory for the MEM stage of the pipelined ARM core. It maps the ALU result onto a word-addressed array above a configurable base address and models a slow memory with a programmable number of wait states. A ready handshake stalls the pipeline until each access completes, and an optional bounds checker flags illegal addresses.

## Interface
- WORD_COUNT, 64: number of 32-bit words; power of two, ≥2.
- BASE_ADDR, 1024: byte address of word 0.
- WAIT_STATES, 2: extra BUSY cycles per access, 0..255.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alu_res_in  input  32  byte address of the access.
- val_rm_in  input  32  store data.
- mem_read_enable_in  input  1  load request.
- mem_write_enable_in  input  1  store request.
- result_out  output  32  load data, registered.
- ready_out  output  1  1 = MEM stage may advance this cycle.
- err_out  output  1  1 = the access just completed was out of range (macro-dependent).

## Operation
- request = mem_read_enable_in | mem_write_enable_in. If both are set, the access is a write; result_out is not updated.
- Index = (alu_res_in − BASE_ADDR) >> 2, truncated to log2(WORD_COUNT) bits.
- States:
  - IDLE
    - On a request: latch address, data and op; cnt ← WAIT_STATES; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY
    - If cnt == 0: perform the access and go to DONE.
      - Write: array[index] ← latched data.
      - Read: result_out ← array[index].
    - Otherwise cnt ← cnt − 1.
  - DONE: go to IDLE unconditionally. There is no back-to-back acceptance; the next request is sampled in IDLE.
- ready_out = (IDLE & ~request) | DONE. This is combinational from the state and the inputs.
- Inputs are ignored after the latch. A request deasserted during BUSY still completes.
- result_out holds its value until the next read access.
- Array contents are not initialised or cleared by rst.
- rst has priority over everything:
  - state → IDLE, cnt → 0, result_out → 0, err_out → 0.
  - An access due on the same edge is aborted; the write is not committed.

## Timing
- Request present in cycle 0 (IDLE): ready_out = 0 in cycles 0 .. WAIT_STATES+1.
- The access occurs at the end of cycle WAIT_STATES+1.
- ready_out = 1 in cycle WAIT_STATES+2 (DONE). The stage advances at the end of that cycle.
- Total stall per access: WAIT_STATES+2 cycles. With WAIT_STATES=0 the stall is 2 cycles.
- The write is visible to a read accepted in any later cycle.
- err_out, when enabled, is a registered 1-cycle pulse coincident with DONE.
- Reset values:
  - result_out = 0, err_out = 0.
  - ready_out = ~request (the block is in IDLE).

## Configuration
- Macro DATA_MEMORY_WS_BOUNDS_CHECK_EN.
- Defined:
  - An access is out of range if alu_res_in < BASE_ADDR, or alu_res_in[1:0] != 0, or (alu_res_in − BASE_ADDR) >> 2 ≥ WORD_COUNT.
  - For an out-of-range access: the write is suppressed, a read loads 0 into result_out, and err_out = 1 in DONE.
  - Handshake timing is unchanged.
- Undefined:
  - err_out is tied to 0.
  - Low two address bits are ignored.
  - The index wraps modulo WORD_COUNT.

## Test plan
- WAIT_STATES=2, write 0xDEADBEEF to 1024, then read 1024. ready_out is low 4 cycles and high in the 5th; result_out = 0xDEADBEEF after the read's access edge.
- Read and write both asserted, address 1028, data 5. Word 1 = 5 on a later read; result_out is unchanged during the write.
- Write 0x11 to 1024, then write 0x22 to 1280 (index 64):
  - Without the macro: read 1024 → 0x22.
  - With the macro: err_out pulses and read 1024 → 0x11.
- Assert rst in BUSY of a write of 0xA5 to 1032. State returns to IDLE, result_out = 0, and a later read of 1032 does not return 0xA5.
- WAIT_STATES=0, read request. ready_out is low 2 cycles, then high 1 cycle; the request deasserted after cycle 0 still completes.
- Hold the request continuously across DONE. The second access is accepted only in the following IDLE cycle; its ready_out pattern matches the first.
